// File: rtl/sobel_frame_sched_if.sv
// Pixel-source, Sobel-engine and result-writer signals of the frame scheduler.
// master = scheduler side, slave = surrounding source/engine/writer.
interface sobel_frame_sched_if #(
    parameter int ADDR_W = 16
);
    logic              start_i;
    logic              pix_valid_i;
    logic [7:0]        pix_i;
    logic              pix_ready_o;
    logic [71:0]       win_o;
    logic              sob_en_o;
    logic              sob_done_i;
    logic [8:0]        sob_data_i;
    logic              out_valid_o;
    logic [7:0]        out_data_o;
    logic [ADDR_W-1:0] out_addr_o;
    logic              busy_o;
    logic              frame_done_o;
    logic              err_o;

    modport master (
        input  start_i, pix_valid_i, pix_i, sob_done_i, sob_data_i,
        output pix_ready_o, win_o, sob_en_o, out_valid_o, out_data_o,
        output out_addr_o, busy_o, frame_done_o, err_o
    );

    modport slave (
        output start_i, pix_valid_i, pix_i, sob_done_i, sob_data_i,
        input  pix_ready_o, win_o, sob_en_o, out_valid_o, out_data_o,
        input  out_addr_o, busy_o, frame_done_o, err_o
    );
endinterface

// File: rtl/sobel_frame_sched.sv
// Frame sequencer for the 3x3 Sobel engine: line buffers, window shifter,
// engine handshake with timeout, saturation and result addressing.
module sobel_frame_sched #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk_i_s,
    input  logic                rst_i_s,
    sobel_frame_sched_if.master bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_RUN, S_GAP, S_DONE
    } state_t;

    state_t            r_state;
    logic [XW-1:0]     r_col;
    logic [YW-1:0]     r_row;
    logic [TW-1:0]     r_tmo;
    logic              r_last;
    logic [7:0]        r_lb0 [IMG_W];
    logic [7:0]        r_lb1 [IMG_W];
    logic [7:0]        r_win [9];
    logic              r_ready;
    logic              r_en;
    logic              r_valid;
    logic              r_fd;
    logic              r_busy;
    logic              r_err;
    logic [7:0]        r_data;
    logic [ADDR_W-1:0] r_addr;

    logic              w_xfer;
    logic              w_interior;
    logic              w_last_pix;
    logic [ADDR_W-1:0] w_addr;

    assign w_xfer     = (r_state == S_ACCEPT) && bus.pix_valid_i && r_ready;
    assign w_interior = (r_row >= YW'(2)) && (r_col >= XW'(2));
    assign w_last_pix = (r_row == YW'(IMG_H - 1)) && (r_col == XW'(IMG_W - 1));
    assign w_addr     = ADDR_W'((int'(r_row) - 1) * IMG_W + int'(r_col) - 1);

    assign bus.pix_ready_o  = r_ready;
    assign bus.sob_en_o     = r_en;
    assign bus.out_valid_o  = r_valid;
    assign bus.out_data_o   = r_data;
    assign bus.out_addr_o   = r_addr;
    assign bus.busy_o       = r_busy;
    assign bus.frame_done_o = r_fd;
    assign bus.err_o        = r_err;

    always_comb begin
        bus.win_o = '0;
        for (int k = 0; k < 9; k++) begin
            bus.win_o[8*k +: 8] = r_win[k];
        end
    end

    // Line buffers: lb1 holds row r-2, lb0 row r-1 at the current column.
    always_ff @(posedge clk_i_s) begin
        if (w_xfer) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= bus.pix_i;
        end
    end

    always_ff @(posedge clk_i_s) begin
        if (rst_i_s) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_tmo   <= '0;
            r_last  <= 1'b0;
            r_ready <= 1'b0;
            r_en    <= 1'b0;
            r_valid <= 1'b0;
            r_fd    <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            r_fd    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_state <= S_ACCEPT;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_err   <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (w_xfer) begin
                        r_win[0] <= r_win[1];
                        r_win[1] <= r_win[2];
                        r_win[2] <= r_lb1[r_col];
                        r_win[3] <= r_win[4];
                        r_win[4] <= r_win[5];
                        r_win[5] <= r_lb0[r_col];
                        r_win[6] <= r_win[7];
                        r_win[7] <= r_win[8];
                        r_win[8] <= bus.pix_i;
                        if (r_col == XW'(IMG_W - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_interior) begin
                            r_state <= S_RUN;
                            r_ready <= 1'b0;
                            r_en    <= 1'b1;
                            r_tmo   <= '0;
                            r_addr  <= w_addr;
                            r_last  <= w_last_pix;
                        end else if (w_last_pix) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_fd    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A done coinciding with the final timeout cycle wins.
                    if (bus.sob_done_i) begin
                        r_data  <= bus.sob_data_i[8] ? 8'hFF : bus.sob_data_i[7:0];
                        r_en    <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_GAP;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_data  <= '0;
                        r_err   <= 1'b1;
                        r_en    <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_last) begin
                        r_state <= S_DONE;
                        r_fd    <= 1'b1;
                    end else begin
                        r_state <= S_ACCEPT;
                        r_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_frame_sched.sv
// Directed frame-level bench for sobel_frame_sched with an engine model
// and an expected-result queue filled as pixels are accepted.
module tb_sobel_frame_sched;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int N   = W * H;
    localparam int TMO = 16;
    localparam int LAT = 5;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [71:0] win;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_frame_sched_if #(.ADDR_W(16)) bus ();

    sobel_frame_sched #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(16), .TIMEOUT(TMO)
    ) dut (
        .clk_i_s(clk),
        .rst_i_s(rst),
        .bus(bus)
    );

    exp_t       sb [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_strobe = 0;
    logic [7:0] img [N];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] eng_res(input int mode, input int w,
                                           input logic [7:0] a, input logic [7:0] b);
        if (mode == 1) return (w % 3 == 0) ? 9'd300 : (w % 3 == 1) ? 9'd255 : 9'd0;
        if (mode == 2) return {1'b0, a} + {1'b0, b};
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [7:0] sat(input logic [8:0] x);
        return (x > 9'd255) ? 8'hFF : x[7:0];
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] v = '0;
        for (int k = 0; k < 9; k++) v[8*k +: 8] = img[(r - 2 + k / 3) * W + c - 2 + k % 3];
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, bus.pix_ready_o, 1'b0);
        chk({tag, "_en"}, bus.sob_en_o, 1'b0);
        chk({tag, "_valid"}, bus.out_valid_o, 1'b0);
        chk({tag, "_fd"}, bus.frame_done_o, 1'b0);
        chk({tag, "_busy"}, bus.busy_o, 1'b0);
        chk({tag, "_err"}, bus.err_o, 1'b0);
        chk({tag, "_win"}, bus.win_o, 72'd0);
        chk({tag, "_data"}, bus.out_data_o, 8'd0);
        chk({tag, "_addr"}, bus.out_addr_o, 16'd0);
    endtask

    // One frame; entered and left on a falling edge.
    task automatic frame(input int mode, input bit stall, input int hang,
                         input int late, input int abort_at, input bit poke);
        int idx = 0, cyc = 0, cnt = 0, wp = 0, run_len = 0, cur_w = -1, r, c;
        bit fin = 0, prev_en = 0, prev_val = 0, exp_en = 0, exp_gap = 0, exp_aft = 0;
        bit pk_s = 0, pk_d = 0, v;
        logic [71:0] hold = '0;
        exp_t e;
        sb.delete();
        n_strobe = 0;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("start_busy", bus.busy_o, 1'b1);
        chk("start_err_clr", bus.err_o, 1'b0);
        while (!fin && cyc < 4000) begin
            if (exp_en) begin
                chk("en_latency", bus.sob_en_o, 1'b1);
                exp_en = 0;
            end
            if (exp_gap) begin
                chk("gap_valid", bus.out_valid_o, 1'b1);
                chk("gap_en_low", bus.sob_en_o, 1'b0);
                exp_gap = 0;
                exp_aft = 1;
            end else if (exp_aft) begin
                chk("gap_next", bus.pix_ready_o | bus.frame_done_o, 1'b1);
                exp_aft = 0;
            end
            if (bus.sob_en_o) begin
                if (!prev_en) begin
                    cur_w++;
                    cnt = 0;
                    run_len = 0;
                    hold = bus.win_o;
                    if (sb.size() > 0) chk("run_window", bus.win_o, sb[0].win);
                    else chk("run_sb_empty", sb.size(), 1);
                end else begin
                    chk("win_stable", bus.win_o, hold);
                end
                cnt++;
                run_len++;
            end else if (prev_en && cur_w == hang) begin
                chk("tmo_len", run_len, TMO);
                chk("tmo_err", bus.err_o, 1'b1);
            end
            if (bus.out_valid_o) begin
                n_strobe++;
                if (sb.size() == 0) begin
                    chk("extra_strobe", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("addr", bus.out_addr_o, e.addr);
                    chk("data", bus.out_data_o, e.data);
                end
            end
            if (bus.frame_done_o) begin
                chk("fd_after_strobe", prev_val, 1'b1);
                chk("fd_sb_empty", sb.size(), 0);
                fin = 1;
            end
            prev_en = bus.sob_en_o;
            prev_val = bus.out_valid_o;
            if (abort_at >= 0 && bus.sob_en_o && cur_w == abort_at) begin
                rst = 1'b1;
                bus.sob_done_i = 1'b0;
                bus.pix_valid_i = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk_zero("abort");
                repeat (6) @(negedge clk);
                chk("abort_quiet", {bus.busy_o, bus.out_valid_o, bus.sob_en_o, bus.frame_done_o}, 4'b0);
                return;
            end
            bus.sob_done_i = 1'b0;
            bus.sob_data_i = '0;
            if (bus.sob_en_o && cur_w != hang && cnt == ((cur_w == late) ? TMO : LAT)) begin
                bus.sob_done_i = 1'b1;
                bus.sob_data_i = eng_res(mode, cur_w, bus.win_o[71:64], bus.win_o[7:0]);
                exp_gap = 1;
            end else if (poke && !pk_d && bus.pix_ready_o && idx > 12) begin
                bus.sob_done_i = 1'b1;
                bus.sob_data_i = 9'h1AB;
                pk_d = 1;
            end
            bus.start_i = poke && !pk_s && bus.sob_en_o;
            if (bus.start_i) pk_s = 1;
            if (idx < N) begin
                v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.pix_valid_i = v;
                bus.pix_i = img[idx];
                if (v && bus.pix_ready_o) begin
                    r = idx / W;
                    c = idx % W;
                    if (r >= 2 && c >= 2) begin
                        e.addr = 16'((r - 1) * W + c - 1);
                        e.win  = exp_win(r, c);
                        e.data = (wp == hang) ? 8'd0
                               : sat(eng_res(mode, wp, img[idx], img[idx - 2 * W - 2]));
                        sb.push_back(e);
                        wp++;
                        exp_en = 1;
                    end
                    idx++;
                end
            end else begin
                bus.pix_valid_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("frame_end", fin, 1'b1);
        bus.pix_valid_i = 1'b0;
        bus.start_i = 1'b0;
        bus.sob_done_i = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy_o, 1'b0);
        chk("fd_pulse", bus.frame_done_o, 1'b0);
        chk("strobes", n_strobe, (W - 2) * (H - 2));
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.pix_valid_i = 1'b0;
        bus.pix_i = '0;
        bus.sob_done_i = 1'b0;
        bus.sob_data_i = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < N; i++) img[i] = 8'(i);
        // ramp, then saturation table, then hang and late-done frames
        frame(0, 0, -1, -1, -1, 0);
        chk("ramp_err", bus.err_o, 1'b0);
        frame(1, 0, -1, -1, -1, 0);
        frame(0, 0, 1, -1, -1, 0);
        chk("err_sticky", bus.err_o, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_sticky_idle", bus.err_o, 1'b1);
        frame(0, 0, -1, 2, -1, 0);
        chk("late_done_no_err", bus.err_o, 1'b0);
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        frame(2, 1, -1, -1, -1, 0);
        frame(2, 0, -1, -1, 3, 0);
        frame(2, 0, -1, -1, -1, 0);
        frame(2, 1, -1, -1, -1, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sobel_frame_sched.md
Name: sobel_frame_sched

Overview:
Frame-level sequencer for the 3x3 Sobel engine. Accepts a raster pixel stream, keeps two line buffers and a 3x3 column shift window, and presents each interior-pixel window to the engine. It holds the engine enable until done, captures and saturates the result, and emits it with its frame address. It sits between the pixel source (image RAM reader) and the result writer.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)
ADDR_W, 16, width of output address
TIMEOUT, 64, max cycles to wait for engine done after enable rises

Ports:
clk_i_s  in  1  clock, rising edge
rst_i_s  in  1  synchronous reset, active-high
start_i  in  1  start frame; sampled only in IDLE
pix_valid_i  in  1  source pixel valid
pix_i  in  8  source pixel, raster order
pix_ready_o  out  1  scheduler accepts pixel
win_o  out  72  window; byte k = bits [8k+7:8k], k=0..8 row-major, k=0 top-left, k=8 bottom-right (newest pixel)
sob_en_o  out  1  engine enable
sob_done_i  in  1  engine result-valid pulse
sob_data_i  in  9  engine result
out_valid_o  out  1  one-cycle result strobe
out_data_o  out  8  saturated result
out_addr_o  out  ADDR_W  result address = (r-1)*IMG_W + (c-1)
busy_o  out  1  high in any state but IDLE
frame_done_o  out  1  one-cycle pulse at end of frame
err_o  out  1  sticky timeout flag; cleared by reset or start

Behaviour:
- Reset: state IDLE. All outputs 0 (pix_ready_o, sob_en_o, out_valid_o, frame_done_o, busy_o, err_o, win_o, out_data_o, out_addr_o). Row/col counters 0. Line-buffer contents are don't-care. Reset mid-frame aborts the frame with no further outputs.
- States:
  - IDLE: on start_i=1, go to ACCEPT, clear counters and err_o. start_i is ignored in all other states.
  - ACCEPT: pix_ready_o=1. Transfer occurs when pix_valid_i & pix_ready_o. On transfer:
    - shift the window columns, write the line buffers, advance col.
    - col wraps IMG_W-1 -> 0 and increments row.
    - If row>=2 and col>=2 for the accepted pixel, go to RUN. Else stay in ACCEPT, or go to DONE if the pixel was last.
  - RUN: sob_en_o=1. win_o is updated on entry and held stable throughout RUN. On sob_done_i=1, latch the result and go to GAP. If TIMEOUT cycles elapse with no done, set err_o, use result 0, and go to GAP.
  - GAP: sob_en_o=0 for exactly one cycle. out_valid_o=1 with out_data_o and out_addr_o. Next state is DONE if the pixel was the last of the frame (r=IMG_H-1, c=IMG_W-1), else ACCEPT.
  - DONE: frame_done_o=1 for one cycle, then IDLE.
- Timing:
  - Transfer at cycle t -> sob_en_o=1 at t+1.
  - Done sampled at cycle d -> out_valid_o=1 and sob_en_o=0 at d+1.
  - pix_ready_o=1 at d+2 (or frame_done_o at d+2).
- Saturation: out_data_o = 255 if sob_data_i > 255, else sob_data_i[7:0]. sob_data_i is treated as unsigned.
- Output count: exactly (IMG_W-2)*(IMG_H-2) strobes per frame, ascending address. Border pixels produce no output.
- Backpressure: pix_ready_o=0 in RUN/GAP/DONE/IDLE. A source holding valid loses no data.
- sob_done_i outside RUN is ignored.
- A done arriving in the same cycle the timeout expires counts as done; err_o stays clear.
- The timeout counter resets on every RUN entry.

Test Plan:
- Ramp frame, IMG_W=IMG_H=4, pix = index 0..15, engine model latency 5, returns win[8]-win[0] -> 4 strobes. addr 5,6,9,10, data 10 each. First window bytes {0,1,2,4,5,6,8,9,10}. frame_done_o one cycle after last strobe.
- Saturation: engine model returns 300 then 255 then 0 -> out_data_o 255, 255, 0.
- Engine hang, TIMEOUT=16: done never asserted for window 2 -> sob_en_o drops after 16 cycles, out_data_o=0, err_o=1 and sticky, remaining windows still processed. Next start_i clears err_o.
- Source stalls: pix_valid_i random 50% with 8x8 frame -> 36 strobes, addresses 9..54 interior only, win_o stable during every RUN.
- Reset asserted in RUN mid-frame -> next cycle all outputs 0, state IDLE. New start_i processes a full fresh frame correctly.
- start_i pulsed while busy_o=1 -> ignored, strobe count unchanged. Spurious sob_done_i in ACCEPT -> no output.
